uart_top: RTL and testbench

Self-contained UART block: one shared 16x-oversampling baud-tick generator, one 8N1 transmitter and one 8N1 receiver. Serves as the serial I/O peripheral between a parallel byte interface and the `tx`/`rx` pins. The block ships as one top plus three submodules: baud generator, transmitter, receiver. Loopback (`tx` wired to `rx`) is the primary verification configuration.

---
 rtl/uart_top_if.sv | 36 +++
 rtl/uart_top.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_uart_top.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_top_if.sv
// uart_top_if: parallel byte side and serial pins of uart_top.
// Build option UART_PARITY_EN adds the parity_err strobe.
interface uart_if #(
   parameter int DIV_W = 16
);
   logic [DIV_W-1:0] baud_division;
   logic             en;
   logic [7:0]       ext_data_in;
   logic             rx;
   logic             tx;
   logic [7:0]       ext_data_out;
   logic             rx_valid;
   logic             tx_busy;
   logic             baud_tick;
`ifdef UART_PARITY_EN
   logic             parity_err;

   modport master (
      output baud_division, en, ext_data_in, rx,
      input  tx, ext_data_out, rx_valid, tx_busy, baud_tick, parity_err
   );
   modport slave (
      input  baud_division, en, ext_data_in, rx,
      output tx, ext_data_out, rx_valid, tx_busy, baud_tick, parity_err
   );
`else
   modport master (
      output baud_division, en, ext_data_in, rx,
      input  tx, ext_data_out, rx_valid, tx_busy, baud_tick
   );
   modport slave (
      input  baud_division, en, ext_data_in, rx,
      output tx, ext_data_out, rx_valid, tx_busy, baud_tick
   );
`endif
endinterface

// File: rtl/uart_top.sv
// uart_top: 16x oversampling baud generator, 8N1 transmitter, 8N1 receiver.
// Build option UART_PARITY_EN inserts an even-parity bit between data and stop
// in both directions and adds the parity_err strobe.

// Free-running tick generator; a new division is picked up at the next wrap.
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_lim;
   logic             r_first;
   logic [DIV_W-1:0] w_live_lim;
   logic [DIV_W-1:0] w_lim;
   logic             w_wrap;

   // terminal count: live value until the first limit is captured, then the held one
   always_comb begin
      w_live_lim = (i_div == '0) ? '0 : i_div - DIV_W'(1);
      w_lim      = r_first ? w_live_lim : r_lim;
      w_wrap     = (r_cnt == w_lim);
   end

   // counter and captured limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_lim   <= '0;
         r_first <= 1'b1;
      end else begin
         r_first <= 1'b0;
         if (r_first || w_wrap) r_lim <= w_live_lim;
         r_cnt <= w_wrap ? '0 : r_cnt + DIV_W'(1);
      end
   end

   assign o_tick = w_wrap & ~r_first;
endmodule

// Transmitter.
//   state  | meaning
//   IDLE   | line high, waiting for en
//   START  | start bit (0)
//   DATA   | 8 data bits, LSB first
//   PARITY | even parity bit (UART_PARITY_EN only)
//   STOP   | stop bit (1); en here chains straight into the next START
module uart_tx (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_en,
   input  logic [7:0] i_data,
   output logic       o_tx,
   output logic       o_busy
);
`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   logic r_par;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif
   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_shift;
   logic [3:0] r_tcnt;
   logic [2:0] r_bcnt;
   logic       w_bit_end;
   logic       w_load;

   assign w_bit_end = i_tick && (r_tcnt == 4'd15);
   assign w_load    = i_en && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_en) w_next = S_START;
         S_START:  if (w_bit_end) w_next = S_DATA;
         S_DATA:   if (w_bit_end && (r_bcnt == 3'd7))
`ifdef UART_PARITY_EN
                      w_next = S_PARITY;
         S_PARITY: if (w_bit_end) w_next = S_STOP;
`else
                      w_next = S_STOP;
`endif
         S_STOP:   if (w_bit_end) w_next = i_en ? S_START : S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // byte latch, shifter and tick/bit counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_tcnt  <= '0;
         r_bcnt  <= '0;
`ifdef UART_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (w_load) begin
         r_shift <= i_data;
         r_tcnt  <= '0;
         r_bcnt  <= '0;
`ifdef UART_PARITY_EN
         r_par   <= ^i_data;
`endif
      end else if ((r_state != S_IDLE) && i_tick) begin
         r_tcnt <= r_tcnt + 4'd1;
         if (w_bit_end && (r_state == S_DATA)) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bcnt  <= r_bcnt + 3'd1;
         end
      end
   end

   // line and busy decode
   always_comb begin
      o_tx   = 1'b1;
      o_busy = (r_state != S_IDLE);
      case (r_state)
         S_START:  o_tx = 1'b0;
         S_DATA:   o_tx = r_shift[0];
`ifdef UART_PARITY_EN
         S_PARITY: o_tx = r_par;
`endif
         default:  o_tx = 1'b1;
      endcase
   end
endmodule

// Receiver.
//   state  | meaning
//   IDLE   | waiting for a synchronized 0
//   START  | re-check the line at mid start bit; 1 means glitch
//   DATA   | sample every 16 ticks, LSB first
//   PARITY | sample and compare even parity (UART_PARITY_EN only)
//   STOP   | sample stop bit; 1 delivers the byte, 0 drops it
module uart_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_rx,
`ifdef UART_PARITY_EN
   output logic       o_parity_err,
`endif
   output logic [7:0] o_data,
   output logic       o_valid
);
`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   logic r_par_bad;
   logic r_perr;
   logic w_par_chk;
   logic w_par_mis;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif
   state_t     r_state;
   state_t     w_next;
   logic       r_sync1;
   logic       r_sync2;
   logic [3:0] r_tcnt;
   logic [2:0] r_bcnt;
   logic [7:0] r_shift;
   logic [7:0] r_data;
   logic       r_valid;
   logic       w_rx;
   logic       w_mid;
   logic       w_bit_end;
   logic       w_shift_en;
   logic       w_load;

   assign w_rx      = r_sync2;
   assign w_mid     = i_tick && (r_tcnt == 4'd7);
   assign w_bit_end = i_tick && (r_tcnt == 4'd15);

   // two-flop synchronizer, idles high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_rx;
         r_sync2 <= r_sync1;
      end
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (!w_rx) w_next = S_START;
         S_START:  if (w_mid) w_next = w_rx ? S_IDLE : S_DATA;
         S_DATA:   if (w_bit_end && (r_bcnt == 3'd7))
`ifdef UART_PARITY_EN
                      w_next = S_PARITY;
         S_PARITY: if (w_bit_end) w_next = S_STOP;
`else
                      w_next = S_STOP;
`endif
         S_STOP:   if (w_bit_end) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // sample strobes
   always_comb begin
      w_shift_en = (r_state == S_DATA) && w_bit_end;
      w_load     = (r_state == S_STOP) && w_bit_end && w_rx;
`ifdef UART_PARITY_EN
      w_par_chk  = (r_state == S_PARITY) && w_bit_end;
      w_par_mis  = w_par_chk && (w_rx != ^r_shift);
      w_load     = w_load && !r_par_bad;
`endif
   end

   // counters, shifter and delivered byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt  <= '0;
         r_bcnt  <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
`ifdef UART_PARITY_EN
         r_par_bad <= 1'b0;
         r_perr    <= 1'b0;
`endif
      end else begin
         r_valid <= w_load;
         if (w_load) r_data <= r_shift;
         if ((r_state == S_IDLE) || ((r_state == S_START) && w_mid)) r_tcnt <= '0;
         else if (i_tick)                                            r_tcnt <= r_tcnt + 4'd1;
         if (r_state == S_START) r_bcnt <= '0;
         else if (w_shift_en)    r_bcnt <= r_bcnt + 3'd1;
         if (w_shift_en) r_shift <= {w_rx, r_shift[7:1]};
`ifdef UART_PARITY_EN
         r_perr <= w_par_mis;
         if (r_state == S_START) r_par_bad <= 1'b0;
         else if (w_par_chk)     r_par_bad <= w_par_mis;
`endif
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
`ifdef UART_PARITY_EN
   assign o_parity_err = r_perr;
`endif
endmodule

// Top: one tick generator shared by independent TX and RX.
module uart_top #(
   parameter int DIV_W = 16
) (
   input logic clk,
   input logic rst,
   uart_if.slave bus
);
   logic w_tick;

   uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
      .clk    (clk),
      .rst    (rst),
      .i_div  (bus.baud_division),
      .o_tick (w_tick)
   );

   uart_tx u_tx (
      .clk    (clk),
      .rst    (rst),
      .i_tick (w_tick),
      .i_en   (bus.en),
      .i_data (bus.ext_data_in),
      .o_tx   (bus.tx),
      .o_busy (bus.tx_busy)
   );

   uart_rx u_rx (
      .clk          (clk),
      .rst          (rst),
      .i_tick       (w_tick),
      .i_rx         (bus.rx),
`ifdef UART_PARITY_EN
      .o_parity_err (bus.parity_err),
`endif
      .o_data       (bus.ext_data_out),
      .o_valid      (bus.rx_valid)
   );

   assign bus.baud_tick = w_tick;
endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top: directed loopback and driven-rx scenarios against a
// cycle-level frame model of the line, tick schedule and received bytes.
`timescale 1ns/1ps
module tb_uart_top;
   localparam int DIV_W = 16;
`ifdef UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_if #(.DIV_W(DIV_W)) bus ();
   logic loop_sel = 1'b1;
   logic drv_rx   = 1'b1;
   assign bus.rx = loop_sel ? bus.tx : drv_rx;

   uart_top #(.DIV_W(DIV_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;
   int n_valid = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int          cyc;
   int          next_tick;
   bit          m_act;
   logic [NB-1:0] m_bits;
   int          m_tk;
   logic [7:0]  m_last;
   logic [7:0]  rxq[$];
   logic        exp_tick;

   function automatic int eff_div();
      return (bus.baud_division == '0) ? 1 : int'(bus.baud_division);
   endfunction

   function automatic logic [NB-1:0] frame_bits(input logic [7:0] d);
      logic [NB-1:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_PARITY_EN
      f[9] = ^d;
`endif
      return f;
   endfunction

   task automatic model_load();
      m_act  = 1'b1;
      m_bits = frame_bits(bus.ext_data_in);
      m_tk   = 0;
      if (loop_sel) rxq.push_back(bus.ext_data_in);
   endtask

   // per-cycle compare, then advance the model to the next cycle
   always @(negedge clk) begin
      if (rst) begin
         check("rst_tx", bus.tx, 1);
         check("rst_busy", bus.tx_busy, 0);
         check("rst_tick", bus.baud_tick, 0);
         check("rst_valid", bus.rx_valid, 0);
         check("rst_data", bus.ext_data_out, 8'h00);
         cyc = 0; m_act = 0; m_tk = 0; m_last = 8'h00;
         rxq.delete();
         next_tick = eff_div() - 1;
      end else begin
         exp_tick = (cyc == next_tick);
         check("baud_tick", bus.baud_tick, exp_tick);
         check("tx_line", bus.tx, m_act ? m_bits[m_tk/16] : 1'b1);
         check("tx_busy", bus.tx_busy, m_act);
         if (bus.rx_valid) begin
            n_valid++;
            if (rxq.size() == 0) check("rx_valid_spurious", bus.rx_valid, 0);
            else m_last = rxq.pop_front();
         end
         check("rx_data", bus.ext_data_out, m_last);
         if (exp_tick) next_tick = cyc + eff_div();
         if (!m_act) begin
            if (bus.en) model_load();
         end else if (exp_tick) begin
            m_tk++;
            if (m_tk == NB*16) begin
               if (bus.en) model_load();
               else m_act = 1'b0;
            end
         end
         cyc++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk); #1;
         if (!bus.tx_busy) break;
      end
      check({"idle_", name}, bus.tx_busy, 0);
   endtask

   task automatic drive_frame(input logic [7:0] d, input logic stop_v, input int stop_ticks);
      int bitc;
      bitc = 16 * eff_div();
      drv_rx = 1'b0; cycles(bitc);
      for (int i = 0; i < 8; i++) begin
         drv_rx = d[i]; cycles(bitc);
      end
`ifdef UART_PARITY_EN
      drv_rx = ^d; cycles(bitc);
`endif
      drv_rx = stop_v; cycles(stop_ticks * eff_div());
      drv_rx = 1'b1;
   endtask

   logic [9:0] exp_wave;
   int         cnt;
   int         v0;

   initial begin
      bus.baud_division = 16'd130;
      bus.en = 1'b0;
      bus.ext_data_in = 8'h00;
      rst = 1'b1;
      cycles(3);
      check("init_tx", bus.tx, 1);
      check("init_data", bus.ext_data_out, 8'h00);
      rst = 1'b0;

      // tick spacing
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (bus.baud_tick) break;
      end
      check("first_tick_seen", bus.baud_tick, 1);
      for (int k = 0; k < 2; k++) begin
         cnt = 0;
         for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1; cnt++;
            if (bus.baud_tick) break;
         end
         check("tick_period", cnt, 130);
      end

      // loopback 0xB4 with en held, change to 0xF0 mid-frame
      exp_wave = 10'b1101101000;
      bus.ext_data_in = 8'hB4;
      bus.en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (!bus.tx) break;
      end
      check("b4_tx_fall", bus.tx, 0);
      check("b4_busy", bus.tx_busy, 1);
      for (int k = 0; k < 10; k++) begin
         cycles(k == 0 ? 1040 : 2080);
         check($sformatf("b4_bit%0d", k), bus.tx, exp_wave[k]);
         if (k == 4) bus.ext_data_in = 8'hF0;
      end
      cycles(700);
      check("rx_b4", bus.ext_data_out, 8'hB4);
      cycles(3*2080);
      check("f0_busy", bus.tx_busy, 1);
      bus.en = 1'b0;
      wait_idle("f0", 25000);
      cycles(20);
      check("rx_f0", bus.ext_data_out, 8'hF0);
      check("rxq_empty_f0", rxq.size(), 0);

      // faster rate for the rest; single 2-clock en pulse
      bus.baud_division = 16'd16;
      cycles(50);
      bus.ext_data_in = 8'hA5;
      bus.en = 1'b1;
      cycles(2);
      bus.en = 1'b0;
      bus.ext_data_in = 8'h00;
      wait_idle("a5", 5000);
      cycles(20);
      check("rx_a5", bus.ext_data_out, 8'hA5);
      check("a5_busy_low", bus.tx_busy, 0);
      check("rxq_empty_a5", rxq.size(), 0);

      // 3-tick glitch on rx
      loop_sel = 1'b0;
      cycles(5);
      v0 = n_valid;
      drv_rx = 1'b0; cycles(48);
      drv_rx = 1'b1; cycles(400);
      check("glitch_no_valid", n_valid - v0, 0);
      check("glitch_data", bus.ext_data_out, 8'hA5);

      // good driven frame, then one with stop bit 0
      rxq.push_back(8'h3C);
      drive_frame(8'h3C, 1'b1, 16);
      cycles(100);
      check("rx_3c", bus.ext_data_out, 8'h3C);
      v0 = n_valid;
      drive_frame(8'h5A, 1'b0, 10);
      cycles(600);
      check("frame_err_no_valid", n_valid - v0, 0);
      check("frame_err_data", bus.ext_data_out, 8'h3C);

      // reset mid-frame, then a clean frame
      loop_sel = 1'b1;
      cycles(10);
      bus.ext_data_in = 8'h96;
      bus.en = 1'b1;
      cycles(1);
      bus.en = 1'b0;
      cycles(5*256);
      check("mid_busy", bus.tx_busy, 1);
      #1 rst = 1'b1;
      #1;
      check("rst_async_tx", bus.tx, 1);
      check("rst_async_busy", bus.tx_busy, 0);
      check("rst_async_data", bus.ext_data_out, 8'h00);
      cycles(2);
      rst = 1'b0;
      cycles(5);
      bus.ext_data_in = 8'h69;
      bus.en = 1'b1;
      cycles(1);
      bus.en = 1'b0;
      wait_idle("69", 5000);
      cycles(20);
      check("rx_69", bus.ext_data_out, 8'h69);
      check("rxq_empty_69", rxq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
